// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch
// resolution and the EX/MEM pipeline register.
module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [1:0]      sel_rs1_src_i,
  input  logic [1:0]      sel_rs2_src_i,
  input  logic [XLEN-1:0] mem_fwd_data_i,
  input  logic [XLEN-1:0] wb_fwd_data_i,
  input  logic [3:0]      alu_op_i,
  input  logic            alu_a_pc_i,
  input  logic            alu_b_imm_i,
  input  logic            branch_i,
  input  logic [2:0]      branch_op_i,
  input  logic [4:0]      sel_rd_i,
  input  logic            reg_write_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  output logic            branch_taken_o,
  output logic [XLEN-1:0] branch_target_o,
  output logic            ex_mem_valid_o,
  output logic [XLEN-1:0] ex_mem_alu_result_o,
  output logic [XLEN-1:0] ex_mem_store_data_o,
  output logic [4:0]      ex_mem_sel_rd_o,
  output logic            ex_mem_reg_write_o,
  output logic            ex_mem_mem_read_o,
  output logic            ex_mem_mem_write_o
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] FU_SRC_REG = 2'd0;
  localparam logic [1:0] FU_SRC_MEM = 2'd1;
  localparam logic [1:0] FU_SRC_WB  = 2'd2;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  logic            cond;

  always_comb begin
    fwd_rs1 = rs1_data_i;
    case (sel_rs1_src_i)
      FU_SRC_MEM: fwd_rs1 = mem_fwd_data_i;
      FU_SRC_WB:  fwd_rs1 = wb_fwd_data_i;
      FU_SRC_REG: fwd_rs1 = rs1_data_i;
      default:    fwd_rs1 = rs1_data_i;
    endcase
  end

  always_comb begin
    fwd_rs2 = rs2_data_i;
    case (sel_rs2_src_i)
      FU_SRC_MEM: fwd_rs2 = mem_fwd_data_i;
      FU_SRC_WB:  fwd_rs2 = wb_fwd_data_i;
      FU_SRC_REG: fwd_rs2 = rs2_data_i;
      default:    fwd_rs2 = rs2_data_i;
    endcase
  end

  assign op_a  = alu_a_pc_i ? pc_i : fwd_rs1;
  assign op_b  = alu_b_imm_i ? imm_i : fwd_rs2;
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_op_i)
      4'd0:  alu_res = op_a + op_b;
      4'd1:  alu_res = op_a - op_b;
      4'd2:  alu_res = op_a << shamt;
      4'd3:  alu_res = {{(XLEN-1){1'b0}},
                        $signed(op_a) < $signed(op_b)};
      4'd4:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'd5:  alu_res = op_a ^ op_b;
      4'd6:  alu_res = op_a >> shamt;
      4'd7:  alu_res = $signed(op_a) >>> shamt;
      4'd8:  alu_res = op_a | op_b;
      4'd9:  alu_res = op_a & op_b;
      4'd10: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // Branches compare forwarded registers, never the immediate.
  always_comb begin
    cond = 1'b0;
    case (branch_op_i)
      3'b000: cond = fwd_rs1 == fwd_rs2;
      3'b001: cond = fwd_rs1 != fwd_rs2;
      3'b100: cond = $signed(fwd_rs1) < $signed(fwd_rs2);
      3'b101: cond = $signed(fwd_rs1) >= $signed(fwd_rs2);
      3'b110: cond = fwd_rs1 < fwd_rs2;
      3'b111: cond = fwd_rs1 >= fwd_rs2;
      default: cond = 1'b0;
    endcase
  end

  assign branch_taken_o = valid_i & branch_i & cond
                        & ~stall_i & ~flush_i;
  assign branch_target_o = pc_i + imm_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_mem_valid_o      <= 1'b0;
      ex_mem_alu_result_o <= '0;
      ex_mem_store_data_o <= '0;
      ex_mem_sel_rd_o     <= '0;
      ex_mem_reg_write_o  <= 1'b0;
      ex_mem_mem_read_o   <= 1'b0;
      ex_mem_mem_write_o  <= 1'b0;
    end else if (flush_i) begin
      ex_mem_valid_o      <= 1'b0;
      ex_mem_reg_write_o  <= 1'b0;
      ex_mem_mem_read_o   <= 1'b0;
      ex_mem_mem_write_o  <= 1'b0;
    end else if (!stall_i) begin
      ex_mem_valid_o      <= valid_i;
      ex_mem_alu_result_o <= alu_res;
      ex_mem_store_data_o <= fwd_rs2;
      ex_mem_sel_rd_o     <= sel_rd_i;
      ex_mem_reg_write_o  <= reg_write_i & valid_i
                           & (sel_rd_i != 5'd0);
      ex_mem_mem_read_o   <= mem_read_i & valid_i;
      ex_mem_mem_write_o  <= mem_write_i & valid_i;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: expected EX/MEM
// contents are queued at drive time and compared after the edge.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, valid;
  logic [31:0] pc, rs1, rs2, imm, memd, wbd;
  logic [1:0]  s1, s2;
  logic [3:0]  op;
  logic        apc, bimm, br;
  logic [2:0]  bop;
  logic [4:0]  rd;
  logic        rw, mr, mw;
  logic        taken;
  logic [31:0] target;
  logic        q_v;
  logic [31:0] q_res, q_st;
  logic [4:0]  q_rd;
  logic        q_rw, q_mr, q_mw;

  typedef struct packed {
    logic        v;
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } exm_t;

  exm_t model;
  exm_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .stall_i(stall), .flush_i(flush),
    .valid_i(valid), .pc_i(pc),
    .rs1_data_i(rs1), .rs2_data_i(rs2),
    .imm_i(imm),
    .sel_rs1_src_i(s1), .sel_rs2_src_i(s2),
    .mem_fwd_data_i(memd), .wb_fwd_data_i(wbd),
    .alu_op_i(op), .alu_a_pc_i(apc),
    .alu_b_imm_i(bimm), .branch_i(br),
    .branch_op_i(bop), .sel_rd_i(rd),
    .reg_write_i(rw), .mem_read_i(mr),
    .mem_write_i(mw),
    .branch_taken_o(taken),
    .branch_target_o(target),
    .ex_mem_valid_o(q_v),
    .ex_mem_alu_result_o(q_res),
    .ex_mem_store_data_o(q_st),
    .ex_mem_sel_rd_o(q_rd),
    .ex_mem_reg_write_o(q_rw),
    .ex_mem_mem_read_o(q_mr),
    .ex_mem_mem_write_o(q_mw)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(
    input logic [1:0] s, input logic [31:0] r,
    input logic [31:0] m, input logic [31:0] w);
    if (s == 2'd1) return m;
    if (s == 2'd2) return w;
    return r;
  endfunction

  function automatic logic [31:0] alu_ref(
    input logic [3:0] o, input logic [31:0] a,
    input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (o)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return 32'($signed(a) >>> sh);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic br_ref(
    input logic [2:0] f, input logic [31:0] a,
    input logic [31:0] b);
    case (f)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic defaults();
    stall = 0; flush = 0; valid = 0;
    pc = 0; rs1 = 0; rs2 = 0; imm = 0;
    memd = 0; wbd = 0; s1 = 0; s2 = 0;
    op = 0; apc = 0; bimm = 0; br = 0; bop = 0;
    rd = 0; rw = 0; mr = 0; mw = 0;
  endtask

  // Inputs must already be driven (after a negedge).
  task automatic step();
    logic [31:0] fa, fb, a, b;
    exm_t nx, got;
    #1;
    fa = fwd(s1, rs1, memd, wbd);
    fb = fwd(s2, rs2, memd, wbd);
    a  = apc ? pc : fa;
    b  = bimm ? imm : fb;
    check("br_taken", 32'(taken),
          32'(valid & br & br_ref(bop, fa, fb)
              & ~stall & ~flush));
    check("br_target", target, pc + imm);
    nx = model;
    if (flush) begin
      nx.v = 0; nx.rw = 0; nx.mr = 0; nx.mw = 0;
    end else if (!stall) begin
      nx.v   = valid;
      nx.res = alu_ref(op, a, b);
      nx.st  = fb;
      nx.rd  = rd;
      nx.rw  = rw & valid & (rd != 5'd0);
      nx.mr  = mr & valid;
      nx.mw  = mw & valid;
    end
    exp_q.push_back(nx);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    model = got;
    check("valid", 32'(q_v), 32'(got.v));
    check("result", q_res, got.res);
    check("store", q_st, got.st);
    check("rd", 32'(q_rd), 32'(got.rd));
    check("reg_write", 32'(q_rw), 32'(got.rw));
    check("mem_read", 32'(q_mr), 32'(got.mr));
    check("mem_write", 32'(q_mw), 32'(got.mw));
  endtask

  task automatic rand_instr();
    valid = 1'($urandom); pc = $urandom;
    rs1 = $urandom; rs2 = $urandom;
    imm = $urandom; memd = $urandom;
    wbd = $urandom;
    s1 = 2'($urandom); s2 = 2'($urandom);
    op = 4'($urandom); apc = 1'($urandom);
    bimm = 1'($urandom); br = 1'($urandom);
    bop = 3'($urandom); rd = 5'($urandom);
    rw = 1'($urandom); mr = 1'($urandom);
    mw = 1'($urandom);
  endtask

  initial begin
    model = '0;
    defaults();
    rst_n = 0;
    #12;
    check("rst_valid", 32'(q_v), 32'd0);
    check("rst_result", q_res, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // MEM forward on rs1
    rs1 = 5; memd = 100; s1 = 2'd1; rs2 = 3;
    op = 0; valid = 1; rd = 5'd1; rw = 1;
    step();
    check("fwd_mem_res", q_res, 32'd103);
    check("fwd_mem_v", 32'(q_v), 32'd1);

    // WB forward on rs2 feeding a store
    @(negedge clk); defaults();
    valid = 1; wbd = 32'hDEAD_BEEF; s2 = 2'd2;
    bimm = 1; imm = 8; rs1 = 32'h1000; mw = 1;
    step();
    check("st_addr", q_res, 32'h1008);
    check("st_data", q_st, 32'hDEAD_BEEF);
    check("st_mw", 32'(q_mw), 32'd1);

    // branches
    @(negedge clk); defaults();
    valid = 1; br = 1; bop = 3'b100;
    rs1 = 32'hFFFF_FFFF; rs2 = 1;
    pc = 32'h40; imm = 32'hFFFF_FFF8;
    #1;
    check("blt_taken", 32'(taken), 32'd1);
    check("blt_target", target, 32'h38);
    step();
    @(negedge clk); bop = 3'b110; #1;
    check("bltu_taken", 32'(taken), 32'd0);
    step();
    @(negedge clk); bop = 3'b100; stall = 1; #1;
    check("blt_stall", 32'(taken), 32'd0);
    step();

    // arithmetic edges
    @(negedge clk); defaults();
    valid = 1; rs1 = 32'hFFFF_FFFF; rs2 = 1;
    rd = 5'd3; rw = 1;
    step();
    check("add_wrap", q_res, 32'd0);
    @(negedge clk); defaults();
    valid = 1; rs1 = 32'h8000_0000; imm = 33;
    bimm = 1; op = 4'd7;
    step();
    check("sra_33", q_res, 32'hC000_0000);
    @(negedge clk); defaults();
    valid = 1; rw = 1; rd = 0; rs1 = 7;
    step();
    check("rd0_rw", 32'(q_rw), 32'd0);

    // random traffic, occasional stall/flush
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      rand_instr();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      step();
    end

    // capture A, then hold through 3 stalls
    @(negedge clk); defaults();
    valid = 1; rs1 = 32'h11; rs2 = 32'h22;
    op = 4'd8; rd = 5'd9; rw = 1; mr = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_instr();
      stall = 1;
      step();
      check("hold_res", q_res, 32'h33);
      check("hold_rd", 32'(q_rd), 32'd9);
    end

    // flush beats stall
    @(negedge clk);
    rand_instr(); valid = 1;
    rw = 1; mr = 1; mw = 1; stall = 1; flush = 1;
    step();
    check("sf_valid", 32'(q_v), 32'd0);
    check("sf_ctrl", {29'd0, q_rw, q_mr, q_mw}, 32'd0);

    // async reset mid-cycle with a live instruction
    @(negedge clk); defaults();
    valid = 1; rs1 = 32'h55; rd = 5'd4; rw = 1; mr = 1;
    step();
    check("pre_rst_v", 32'(q_v), 32'd1);
    #2;
    rst_n = 0;
    #1;
    check("arst_valid", 32'(q_v), 32'd0);
    check("arst_result", q_res, 32'd0);
    check("arst_rd", 32'(q_rd), 32'd0);
    check("arst_ctrl", {29'd0, q_rw, q_mr, q_mw}, 32'd0);
    model = '0;
    @(negedge clk);
    rst_n = 1;
    defaults();
    step();
    check("post_rst_v", 32'(q_v), 32'd0);
    @(negedge clk);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
